// File: rtl/match_lock_detect.sv
// match_lock_detect
// Pattern-sync lock detector that sits after a 4-bit equality checker.
// - Counts runs of consecutive valid matches and declares lock after LOCK_CNT of them.
// - Drops lock after UNLOCK_CNT consecutive valid misses.
// - Keeps a saturating total of valid matches.
// Optional build macro: MATCH_LOCK_MISS_COUNT_EN adds a saturating miss_total output.
// All outputs are registered, so each sample shows up one cycle after it is taken.
// rst (synchronous, active-high) and clear have the same effect on all state.

module match_lock_detect #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_match,
    output logic             locked,
    output logic             lock_pulse,
    output logic             unlock_pulse,
    output logic [1:0]       state,
    output logic [3:0]       run_len,
    output logic [CNT_W-1:0] match_total
`ifdef MATCH_LOCK_MISS_COUNT_EN
    ,
    output logic [CNT_W-1:0] miss_total
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0]       LOCK_LIM   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_LIM = 4'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [3:0]       r_run;
    logic             r_locked;
    logic             r_lock_pulse;
    logic             r_unlock_pulse;
    logic [CNT_W-1:0] r_match_total;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_run_nxt;
    logic [3:0]       w_run_inc;
    logic             w_locked_nxt;
    logic             w_lock_pulse_nxt;
    logic             w_unlock_pulse_nxt;
    logic             w_match_inc;
    logic             w_soft_rst;

    // Any reset source discards the current sample and returns everything to idle.
    assign w_soft_rst = rst | clear;
    assign w_run_inc  = r_run + 4'd1;

    // Saturating match counter increments only while below all-ones.
    assign w_match_inc = in_valid & in_match & (r_match_total != CNT_MAX);

    // State register, run length, pulses and counters; all outputs come from here.
    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_state        <= ST_SEARCH;
            r_run          <= 4'd0;
            r_locked       <= 1'b0;
            r_lock_pulse   <= 1'b0;
            r_unlock_pulse <= 1'b0;
            r_match_total  <= {CNT_W{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_run          <= w_run_nxt;
            r_locked       <= w_locked_nxt;
            r_lock_pulse   <= w_lock_pulse_nxt;
            r_unlock_pulse <= w_unlock_pulse_nxt;
            if (w_match_inc) begin
                r_match_total <= r_match_total + CNT_ONE;
            end else begin
                r_match_total <= r_match_total;
            end
        end
    end

    // Next-state and next run length from the current state and the qualified sample.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        case (r_state)
            ST_SEARCH: begin
                if (in_valid && in_match) begin
                    if (LOCK_LIM == 4'd1) begin
                        w_state_nxt = ST_LOCKED;
                        w_run_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_VERIFY;
                        w_run_nxt   = 4'd1;
                    end
                end else if (in_valid) begin
                    w_state_nxt = ST_SEARCH;
                    w_run_nxt   = 4'd0;
                end else begin
                    w_state_nxt = r_state;
                    w_run_nxt   = r_run;
                end
            end
            ST_VERIFY: begin
                if (in_valid && in_match) begin
                    if (w_run_inc == LOCK_LIM) begin
                        w_state_nxt = ST_LOCKED;
                        w_run_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_VERIFY;
                        w_run_nxt   = w_run_inc;
                    end
                end else if (in_valid) begin
                    w_state_nxt = ST_SEARCH;
                    w_run_nxt   = 4'd0;
                end else begin
                    w_state_nxt = r_state;
                    w_run_nxt   = r_run;
                end
            end
            ST_LOCKED: begin
                // In LOCKED the run length tracks consecutive misses instead.
                if (in_valid && in_match) begin
                    w_state_nxt = ST_LOCKED;
                    w_run_nxt   = 4'd0;
                end else if (in_valid) begin
                    if (w_run_inc == UNLOCK_LIM) begin
                        w_state_nxt = ST_SEARCH;
                        w_run_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_run_nxt   = w_run_inc;
                    end
                end else begin
                    w_state_nxt = r_state;
                    w_run_nxt   = r_run;
                end
            end
            default: begin
                // Encoding 3 is unused; fall back to a clean SEARCH.
                w_state_nxt = ST_SEARCH;
                w_run_nxt   = 4'd0;
            end
        endcase
    end

    // Output decode: level and edge flags derived from the state transition.
    always_comb begin
        w_locked_nxt       = (w_state_nxt == ST_LOCKED);
        w_lock_pulse_nxt   = (w_state_nxt == ST_LOCKED) && (r_state != ST_LOCKED);
        w_unlock_pulse_nxt = (r_state == ST_LOCKED) && (w_state_nxt != ST_LOCKED);
    end

    assign state        = r_state;
    assign run_len      = r_run;
    assign locked       = r_locked;
    assign lock_pulse   = r_lock_pulse;
    assign unlock_pulse = r_unlock_pulse;
    assign match_total  = r_match_total;

`ifdef MATCH_LOCK_MISS_COUNT_EN
    logic [CNT_W-1:0] r_miss_total;
    logic             w_miss_inc;

    assign w_miss_inc = in_valid & ~in_match & (r_miss_total != CNT_MAX);

    // Saturating count of valid misses in any state.
    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_miss_total <= {CNT_W{1'b0}};
        end else if (w_miss_inc) begin
            r_miss_total <= r_miss_total + CNT_ONE;
        end else begin
            r_miss_total <= r_miss_total;
        end
    end

    assign miss_total = r_miss_total;
`endif

endmodule

// File: tb/tb_match_lock_detect.sv
// Testbench for match_lock_detect: a directed vector table followed by
// randomized traffic checked against a rule-level reference model.
// A second instance with CNT_W = 2 exercises counter saturation.

module tb_match_lock_detect;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_match;

    logic       locked, lock_pulse, unlock_pulse;
    logic [1:0] state;
    logic [3:0] run_len;
    logic [7:0] match_total;

    logic       s_locked, s_lock_pulse, s_unlock_pulse;
    logic [1:0] s_state;
    logic [3:0] s_run_len;
    logic [1:0] s_match_total;

`ifdef MATCH_LOCK_MISS_COUNT_EN
    logic [7:0] miss_total;
    logic [1:0] s_miss_total;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    match_lock_detect #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_match(in_match),
        .locked(locked), .lock_pulse(lock_pulse), .unlock_pulse(unlock_pulse),
        .state(state), .run_len(run_len), .match_total(match_total)
`ifdef MATCH_LOCK_MISS_COUNT_EN
        , .miss_total(miss_total)
`endif
    );

    match_lock_detect #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_match(in_match),
        .locked(s_locked), .lock_pulse(s_lock_pulse), .unlock_pulse(s_unlock_pulse),
        .state(s_state), .run_len(s_run_len), .match_total(s_match_total)
`ifdef MATCH_LOCK_MISS_COUNT_EN
        , .miss_total(s_miss_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Apply one sample; outputs are sampled 1 time unit after the edge.
    task automatic apply(input bit r, input bit c, input bit v, input bit m);
        rst = r; clear = c; in_valid = v; in_match = m;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (rule level) ----------------
    int ms, mrun, mtot, mtot2, mmiss, mmiss2;
    bit mlp, mup;

    function automatic int sat_inc(input int x, input int maxv);
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit v, input bit m);
        if (r || c) begin
            ms = 0; mrun = 0; mlp = 0; mup = 0;
            mtot = 0; mtot2 = 0; mmiss = 0; mmiss2 = 0;
        end else begin
            mlp = 0; mup = 0;
            if (v) begin
                if (m) begin
                    mtot = sat_inc(mtot, 255); mtot2 = sat_inc(mtot2, 3);
                end else begin
                    mmiss = sat_inc(mmiss, 255); mmiss2 = sat_inc(mmiss2, 3);
                end
                if (ms == 2) begin
                    if (m) mrun = 0;
                    else begin
                        mrun = mrun + 1;
                        if (mrun == 2) begin ms = 0; mrun = 0; mup = 1; end
                    end
                end else if (m) begin
                    mrun = mrun + 1;
                    if (mrun == 4) begin ms = 2; mrun = 0; mlp = 1; end
                    else ms = 1;
                end else begin
                    ms = 0; mrun = 0;
                end
            end
        end
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d_state", cyc), state, ms);
        chk($sformatf("rnd%0d_run", cyc), run_len, mrun);
        chk($sformatf("rnd%0d_locked", cyc), locked, (ms == 2) ? 1 : 0);
        chk($sformatf("rnd%0d_lp", cyc), lock_pulse, mlp);
        chk($sformatf("rnd%0d_up", cyc), unlock_pulse, mup);
        chk($sformatf("rnd%0d_total", cyc), match_total, mtot);
        chk($sformatf("rnd%0d_total_sat", cyc), s_match_total, mtot2);
        chk($sformatf("rnd%0d_pulse_excl", cyc), lock_pulse & unlock_pulse, 0);
`ifdef MATCH_LOCK_MISS_COUNT_EN
        chk($sformatf("rnd%0d_miss", cyc), miss_total, mmiss);
        chk($sformatf("rnd%0d_miss_sat", cyc), s_miss_total, mmiss2);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit r, c, v, m;
        int st, run, lp, up, tot;
    } vec_t;

    vec_t tbl[24];

    initial begin
        // reset held two cycles with a valid match presented
        tbl[0]  = '{1,0,1,1, 0,0,0,0,0};
        tbl[1]  = '{1,0,1,1, 0,0,0,0,0};
        // lock acquire
        tbl[2]  = '{0,0,1,1, 1,1,0,0,1};
        tbl[3]  = '{0,0,1,1, 1,2,0,0,2};
        tbl[4]  = '{0,0,1,1, 1,3,0,0,3};
        tbl[5]  = '{0,0,1,1, 2,0,1,0,4};
        tbl[6]  = '{0,0,0,0, 2,0,0,0,4};
        // lock loss: miss, match, miss, miss
        tbl[7]  = '{0,0,1,0, 2,1,0,0,4};
        tbl[8]  = '{0,0,1,1, 2,0,0,0,5};
        tbl[9]  = '{0,0,1,0, 2,1,0,0,5};
        tbl[10] = '{0,0,1,0, 0,0,0,1,5};
        tbl[11] = '{0,0,1,0, 0,0,0,0,5};
        // broken run, then lock with bubbles in between
        tbl[12] = '{0,0,1,1, 1,1,0,0,6};
        tbl[13] = '{0,0,1,1, 1,2,0,0,7};
        tbl[14] = '{0,0,1,0, 0,0,0,0,7};
        tbl[15] = '{0,0,1,1, 1,1,0,0,8};
        tbl[16] = '{0,0,0,1, 1,1,0,0,8};
        tbl[17] = '{0,0,1,1, 1,2,0,0,9};
        tbl[18] = '{0,0,1,1, 1,3,0,0,10};
        tbl[19] = '{0,0,0,0, 1,3,0,0,10};
        tbl[20] = '{0,0,1,1, 2,0,1,0,11};
        // clear while LOCKED: no unlock pulse
        tbl[21] = '{0,1,1,1, 0,0,0,0,0};
        tbl[22] = '{0,0,1,1, 1,1,0,0,1};
        // reset mid-VERIFY
        tbl[23] = '{1,0,1,1, 0,0,0,0,0};
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_match = 1'b0;
        #1;

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].m);
            chk($sformatf("vec%0d_state", i), state, tbl[i].st);
            chk($sformatf("vec%0d_run", i), run_len, tbl[i].run);
            chk($sformatf("vec%0d_locked", i), locked, (tbl[i].st == 2) ? 1 : 0);
            chk($sformatf("vec%0d_lp", i), lock_pulse, tbl[i].lp);
            chk($sformatf("vec%0d_up", i), unlock_pulse, tbl[i].up);
            chk($sformatf("vec%0d_total", i), match_total, tbl[i].tot);
            chk($sformatf("vec%0d_total_sat", i), s_match_total, (tbl[i].tot > 3) ? 3 : tbl[i].tot);
        end

        // Saturation: 5 matches after reset -> 1,2,3,3,3 on the 2-bit counter
        apply(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 1);
            chk($sformatf("sat%0d_total", i), s_match_total, (i + 1 > 3) ? 3 : i + 1);
        end
`ifdef MATCH_LOCK_MISS_COUNT_EN
        // 5 misses -> miss counter saturates at 3
        apply(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 0);
            chk($sformatf("satmiss%0d", i), s_miss_total, (i + 1 > 3) ? 3 : i + 1);
            chk($sformatf("miss%0d", i), miss_total, i + 1);
        end
`endif

        // Randomized traffic against the reference model
        apply(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, c, v, m;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 4) != 0);
            apply(r, c, v, m);
            model_step(r, c, v, m);
            check_model(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/match_lock_detect.md
Name: match_lock_detect

Overview:
- Downstream consumer of the 4-bit equality checker's single-bit `o` result, qualified by a valid strobe.
- Tracks runs of consecutive matches and declares "lock" once a programmable run length is reached.
- Drops lock after a programmable number of consecutive misses.
- Keeps a saturating count of all matches, for word-alignment / pattern-sync detection on a nibble stream.

Parameters:
- LOCK_CNT, 4, consecutive valid matches needed to enter LOCKED; legal range 1..15.
- UNLOCK_CNT, 2, consecutive valid misses while LOCKED needed to return to SEARCH; legal range 1..15.
- CNT_W, 8, width of match_total counter; minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear; same effect as rst on all state and counters.
- in_valid  input  1  in_match is meaningful this cycle.
- in_match  input  1  equality result from the upstream checker (1 = A equals B).
- locked  output  1  high while state is LOCKED.
- lock_pulse  output  1  one-cycle pulse on entry to LOCKED.
- unlock_pulse  output  1  one-cycle pulse on exit from LOCKED.
- state  output  2  0 = SEARCH, 1 = VERIFY, 2 = LOCKED; encoding 3 is unused.
- run_len  output  4  current consecutive-match count (SEARCH/VERIFY) or consecutive-miss count (LOCKED).
- match_total  output  CNT_W  saturating count of valid matches since reset/clear.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- All outputs are registered. A sample presented at edge N is reflected in the outputs after edge N, i.e. one-cycle latency.
- Reset/clear values: state = SEARCH, run_len = 0, locked = 0, lock_pulse = 0, unlock_pulse = 0, match_total = 0.
- rst or clear asserted: that cycle's sample is discarded. This applies even mid-VERIFY or while LOCKED, and no unlock_pulse is generated.
- Cycles with in_valid = 0: no state, run_len or counter change; pulses deassert.
- SEARCH:
  - valid & match: run_len = 1, then go to VERIFY. If LOCK_CNT = 1, go directly to LOCKED with run_len = 0 and lock_pulse = 1.
  - valid & !match: stay in SEARCH, run_len = 0.
- VERIFY:
  - valid & match: run_len + 1. When the new value equals LOCK_CNT, go to LOCKED, run_len = 0, lock_pulse = 1.
  - valid & !match: go to SEARCH, run_len = 0.
- LOCKED:
  - valid & match: run_len = 0 (miss run broken).
  - valid & !match: run_len + 1. When the new value equals UNLOCK_CNT, go to SEARCH, run_len = 0, unlock_pulse = 1.
- An unlock transition never re-arms in the same cycle. The sample that caused the unlock does not count toward a new match run.
- match_total increments on every valid & match in any state. It holds at all-ones (2^CNT_W - 1) and never wraps.
- Unused state encoding 3: recovers to SEARCH on the next edge with run_len = 0.
- lock_pulse and unlock_pulse are never high in the same cycle.

Optional Feature:
- Macro MATCH_LOCK_MISS_COUNT_EN.
- Defined: adds output miss_total (output, CNT_W bits), a saturating count of valid & !match samples in any state. It is cleared by rst/clear and holds at all-ones.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles with in_valid = 1, in_match = 1 -> state = 0, run_len = 0, match_total = 0, locked = 0 throughout.
- Lock acquire (defaults): 4 consecutive valid matches -> run_len 1, 2, 3, then state = 2, locked = 1, lock_pulse high exactly 1 cycle on the 4th-sample update, match_total = 4.
- Broken run: matches M, M, miss, M, M, M, M -> return to SEARCH after the miss, lock only after the last 4 matches, match_total = 6.
- Lock loss: while LOCKED, miss, match, miss, miss -> run_len 1, 0, 1, then state = 0, unlock_pulse 1 cycle, locked = 0.
- Gaps and clear: in_valid = 0 bubbles between matches -> lock still after 4 valid matches. clear asserted while LOCKED with in_valid = 1, in_match = 1 -> all outputs return to reset values, no unlock_pulse.
- Saturation: CNT_W = 2, 5 valid matches -> match_total 1, 2, 3, 3, 3. With MATCH_LOCK_MISS_COUNT_EN defined, 5 misses -> miss_total saturates at 3.
